pipe_stage_reg: RTL

Parametrised, elastic pipeline stage register. It replaces the fixed EX/MEM register and is the single building block for every inter-stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB. It carries an opaque payload, such as ALU result plus `controlsgs_t`, with valid/ready handshaking, synchronous flush and an optional skid slot that breaks the combinational ready path. It also provides a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_slot.sv | 43 ++++
 rtl/pipe_stage_reg.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Desc     : Shared types and defaults for the elastic pipeline stage register.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int unsigned PIPE_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module   : pipe_slot
// Desc     : One payload register with its valid bit (load / clear-valid).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clr_valid,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Clearing the valid bit leaves the payload untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (load) begin
                r_data <= d;
            end
            if (clr_valid) begin
                r_valid <= 1'b0;
            end else if (load) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign q     = r_data;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Desc     : Elastic valid/ready pipeline stage with flush, optional skid slot
//            and a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SKID  = 0,
    parameter int CNT_W = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             cnt_clr
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;
    logic             w_main_load;
    logic             w_main_clr;
    logic             w_main_valid;

    pipe_slot #(.WIDTH(WIDTH)) u_main (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (w_main_load),
        .clr_valid (w_main_clr),
        .d         (w_main_d),
        .q         (w_main_q),
        .valid     (w_main_valid)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_state_t      r_state;
            pipe_state_t      w_next_state;
            logic             r_s_ready;
            logic [WIDTH-1:0] w_skid_q;
            logic             w_skid_load;
            logic             w_skid_clr;
            logic             w_skid_valid;

            pipe_slot #(.WIDTH(WIDTH)) u_skid (
                .clk       (clk),
                .reset_n   (reset_n),
                .load      (w_skid_load),
                .clr_valid (w_skid_clr),
                .d         (s_data),
                .q         (w_skid_q),
                .valid     (w_skid_valid)
            );

            // s_ready is a registered decode of the next state, so nothing on
            // the m-side reaches the s-side combinationally.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_state   <= ST_EMPTY;
                    r_s_ready <= 1'b1;
                end else begin
                    r_state   <= w_next_state;
                    r_s_ready <= (w_next_state != ST_SKID);
                end
            end

            always_comb begin
                w_next_state = r_state;
                if (flush) begin
                    w_next_state = ST_EMPTY;
                end else begin
                    case (r_state)
                        ST_EMPTY: if (s_valid) w_next_state = ST_FULL;
                        ST_FULL: begin
                            if (s_valid && !m_ready) begin
                                w_next_state = ST_SKID;
                            end else if (!s_valid && m_ready) begin
                                w_next_state = ST_EMPTY;
                            end
                        end
                        ST_SKID:  if (m_ready) w_next_state = ST_FULL;
                        default:  w_next_state = ST_EMPTY;
                    endcase
                end
            end

            always_comb begin
                w_main_load = 1'b0;
                w_main_clr  = 1'b0;
                w_skid_load = 1'b0;
                w_skid_clr  = 1'b0;
                if (flush) begin
                    w_main_clr = 1'b1;
                    w_skid_clr = 1'b1;
                end else begin
                    case (r_state)
                        ST_EMPTY: w_main_load = s_valid;
                        ST_FULL: begin
                            if (s_valid && m_ready) begin
                                w_main_load = 1'b1;
                            end else if (s_valid) begin
                                w_skid_load = 1'b1;
                            end else if (m_ready) begin
                                w_main_clr = 1'b1;
                            end
                        end
                        ST_SKID: begin
                            if (m_ready) begin
                                w_main_load = 1'b1;
                                w_skid_clr  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            // An occupied skid slot always drains into main before new data.
            assign w_main_d = w_skid_valid ? w_skid_q : s_data;
            assign s_ready  = r_s_ready;
        end else begin : g_single
            logic w_s_ready;

            assign w_s_ready   = m_ready || !w_main_valid;
            assign w_main_load = s_valid && w_s_ready && !flush;
            assign w_main_clr  = flush || (w_main_valid && m_ready && !w_main_load);
            assign w_main_d    = s_data;
            assign s_ready     = w_s_ready;
        end
    endgenerate

    assign m_valid = w_main_valid;
    assign m_data  = w_main_q;

    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_main_valid && !m_ready && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
